// File: rtl/fifo_reader.sv
// fifo_reader: pulls words from a 1-cycle-latency sync FIFO into a 2-entry buffer
// and presents them as a valid/ready stream. Define FIFO_READER_COUNT_EN to build the rd_count counter.
module fifo_reader #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_r_en,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  rd_count
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] slot0, slot1;
  logic [1:0]        cnt;
  logic              inflight;
  logic              pop;
  logic [1:0]        used;

  assign m_valid = (cnt != 2'd0);
  assign m_data  = m_valid ? slot0 : '0;
  assign pop     = m_valid & m_ready;

  // A word leaving on this edge frees its slot, so reads can stream at one per cycle.
  assign used = cnt + {1'b0, inflight} - {1'b0, pop};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fifo_r_en = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE:  if (enable) state_nxt = RUN;
      RUN: begin
        if (!enable) state_nxt = DRAIN;
        fifo_r_en = enable && !fifo_empty && (used < 2'd2);
      end
      DRAIN: begin
        if (enable)                           state_nxt = RUN;
        else if (!inflight && cnt == 2'd0)    state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // slot0 is always the oldest word; a capture lands behind whatever survives the pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot0    <= '0;
      slot1    <= '0;
      cnt      <= 2'd0;
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_r_en;
      case ({inflight, pop})
        2'b10: begin
          if (cnt == 2'd0) slot0 <= fifo_data;
          else             slot1 <= fifo_data;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          cnt   <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) slot0 <= fifo_data;
          else begin
            slot0 <= slot1;
            slot1 <= fifo_data;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FIFO_READER_COUNT_EN
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   count_q <= '0;
    else if (pop) count_q <= count_q + CNT_W'(1);
  end

  assign rd_count = count_q;
`else
  assign rd_count = '0;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: queue-backed FIFO model, in-order delivery scoreboard,
// a per-cycle vector table and directed corner sequences, then random traffic.
module tb_fifo_reader;
  localparam int CNT_W = 2;

  logic       clk, reset, enable, m_ready;
  logic       fifo_empty, fifo_r_en, m_valid, busy;
  logic [7:0] fifo_data = 8'h00;
  logic [7:0] m_data;
  logic [CNT_W-1:0] rd_count;

  fifo_reader #(.DATA_W(8), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_r_en(fifo_r_en), .m_valid(m_valid),
    .m_data(m_data), .m_ready(m_ready), .busy(busy), .rd_count(rd_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // sync FIFO model: data appears the edge after a sampled read strobe
  logic [7:0] mem [0:1023];
  int wp = 0, rp = 0;
  assign fifo_empty = (rp == wp);
  always @(posedge clk) begin
    if (fifo_r_en && rp != wp) begin
      fifo_data <= mem[rp % 1024];
      rp <= rp + 1;
    end
  end

  int total = 0, bad = 0;
  logic [7:0] exp_q[$];
  int issued, delivered;
  logic prev_stall;
  logic [7:0] prev_data;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  function automatic int exp_count(input int n);
`ifdef FIFO_READER_COUNT_EN
    return n % (1 << CNT_W);
`else
    return 0;
`endif
  endfunction

  task automatic push(input logic [7:0] d);
    mem[wp % 1024] = d;
    wp++;
    exp_q.push_back(d);
  endtask

  // one cycle: drive at negedge, then score the settled outputs against the model
  task automatic step(input logic en, input logic rdy);
    logic [7:0] want;
    @(negedge clk);
    enable  = en;
    m_ready = rdy;
    #1;
    chk("ren_when_empty", fifo_r_en & fifo_empty, 0);
    if (prev_stall) begin
      chk("stall_valid", m_valid, 1);
      chk("stall_data", m_data, prev_data);
    end
    chk("rd_count", rd_count, exp_count(delivered));
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_word got=%0h want=none", m_data);
      end else begin
        want = exp_q.pop_front();
        chk("order", m_data, want);
      end
      delivered++;
    end
    chk("occupancy_le_2", (issued + int'(fifo_r_en) - delivered) <= 2, 1);
    if (fifo_r_en) issued++;
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
  endtask

  // Asserts reset immediately (mid-cycle), checks the cleared outputs, releases after two edges.
  task automatic do_reset(input bit flush);
    reset = 1'b0;
    enable = 1'b0;
    m_ready = 1'b0;
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_r_en", fifo_r_en, 0);
    chk("rst_rd_count", rd_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_m_data", m_data, 0);
    exp_q.delete();
    if (flush) wp = rp;
    else for (int p = rp; p < wp; p++) exp_q.push_back(mem[p % 1024]);
    issued = 0;
    delivered = 0;
    prev_stall = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    logic en, rdy, ren, vld;
    logic [7:0] data;
    logic bsy;
  } vec_t;
  vec_t tbl [7];

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; m_ready = 1'b0;
    #2;
    do_reset(1);

    // 3,9,7 preloaded, streaming at full rate
    tbl[0] = '{1, 1, 0, 0, 8'h00, 0};
    tbl[1] = '{1, 1, 1, 0, 8'h00, 1};
    tbl[2] = '{1, 1, 1, 0, 8'h00, 1};
    tbl[3] = '{1, 1, 1, 1, 8'h03, 1};
    tbl[4] = '{1, 1, 0, 1, 8'h09, 1};
    tbl[5] = '{1, 1, 0, 1, 8'h07, 1};
    tbl[6] = '{1, 1, 0, 0, 8'h00, 1};
    push(8'd3); push(8'd9); push(8'd7);
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].en, tbl[i].rdy);
      chk($sformatf("vec%0d_r_en", i), fifo_r_en, tbl[i].ren);
      chk($sformatf("vec%0d_valid", i), m_valid, tbl[i].vld);
      chk($sformatf("vec%0d_data", i), m_data, tbl[i].data);
      chk($sformatf("vec%0d_busy", i), busy, tbl[i].bsy);
    end
    chk("rd_count_3", rd_count, exp_count(3));

    // backpressure: 8 words, only 2 reads may be outstanding
    do_reset(1);
    for (int i = 0; i < 8; i++) push(8'h20 + 8'(i));
    begin
      int reads = 0;
      for (int i = 0; i < 8; i++) begin
        step(1, 0);
        if (fifo_r_en) reads++;
      end
      chk("bp_reads", reads, 2);
      chk("bp_r_en_low", fifo_r_en, 0);
      chk("bp_hold_valid", m_valid, 1);
      chk("bp_hold_data", m_data, 8'h20);
      step(1, 1);
      chk("bp_first", m_data, 8'h20);
      step(1, 1);
      chk("bp_second", m_data, 8'h21);
    end

    // reset mid-stream with A buffered and B in flight: B is lost, C comes next
    do_reset(1);
    push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
    repeat (4) step(1, 0);
    chk("mid_valid", m_valid, 1);
    chk("mid_data", m_data, 8'hA1);
    do_reset(0);
    begin
      bit seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
        step(1, 1);
        if (m_valid) begin
          seen = 1;
          chk("post_reset_word", m_data, 8'hA3);
        end
      end
      chk("post_reset_seen", seen, 1);
    end

    // enable drops one cycle after a read issues
    do_reset(1);
    for (int i = 0; i < 5; i++) push(8'h40 + 8'(i));
    step(1, 1);
    step(1, 1);
    chk("drn_issue", fifo_r_en, 1);
    step(0, 1);
    chk("drn_no_read", fifo_r_en, 0);
    step(0, 1);
    chk("drn_busy", busy, 1);
    chk("drn_valid", m_valid, 1);
    chk("drn_data", m_data, 8'h40);
    begin
      int extra = 0;
      for (int i = 0; i < 20 && busy; i++) begin
        step(0, 1);
        if (fifo_r_en) extra++;
      end
      chk("drn_extra_reads", extra, 0);
      chk("drn_idle", busy, 0);
      chk("drn_delivered", delivered, 1);
    end

    // empty FIFO throughout
    do_reset(1);
    begin
      int ren_seen = 0, vld_seen = 0;
      for (int i = 0; i < 10; i++) begin
        step(1, 1);
        if (fifo_r_en) ren_seen++;
        if (m_valid) vld_seen++;
      end
      chk("empty_r_en", ren_seen, 0);
      chk("empty_valid", vld_seen, 0);
      chk("empty_busy", busy, 1);
    end

    // 5 transfers: rd_count wraps (or stays 0 when the counter is not built)
    do_reset(1);
    for (int i = 0; i < 5; i++) push(8'h50 + 8'(i));
    for (int i = 0; i < 30 && delivered < 5; i++) step(1, 1);
    chk("five_delivered", delivered, 5);
    step(1, 1);
    chk("rd_count_5", rd_count, exp_count(5));

    // random traffic against the scoreboard
    do_reset(1);
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 8) != 0, (i / 100) % 2 == 0 ? ($urandom % 4 != 0) : ($urandom % 3 == 0));
      if ($urandom % 2 == 0) push(8'($urandom));
    end
    for (int i = 0; i < 300 && (exp_q.size() > 0 || m_valid); i++) step(1, 1);
    chk("rand_drained", exp_q.size(), 0);
    chk("rand_rd_count", rd_count, exp_count(delivered));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
